loop_overdub_mixer: RTL

- Sits directly downstream of the audio looper, in the 24-bit audio path ahead of the CODEC output.
- Sums the live (dry) sample with the looper playback (wet) sample, with a click-free linear gain ramp on the wet path whenever loop playback is enabled or disabled.
- All sample-rate activity is qualified by the single-cycle sample strobe from the looper's signal cutter; the output is registered and saturated.

---
 rtl/loop_overdub_mixer_if.sv | 34 +++
 rtl/loop_overdub_mixer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/loop_overdub_mixer_if.sv
// rtl/loop_overdub_mixer_if.sv - sample-rate bus between looper, overdub mixer and CODEC path
// Optional clip_led signal is present only when MIX_CLIP_HOLD_EN is defined.
interface loop_overdub_mixer_if #(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 8
);
   logic                     sample_tick;
   logic signed [DATA_W-1:0] dry;
   logic signed [DATA_W-1:0] wet;
   logic                     wet_en;
   logic signed [DATA_W-1:0] out;
   logic                     out_valid;
   logic [GAIN_W:0]          gain;
   logic                     fading;
`ifdef MIX_CLIP_HOLD_EN
   logic                     clip_led;
`endif

   modport master (
      output sample_tick, dry, wet, wet_en,
      input  out, out_valid, gain, fading
`ifdef MIX_CLIP_HOLD_EN
      , input clip_led
`endif
   );

   modport slave (
      input  sample_tick, dry, wet, wet_en,
      output out, out_valid, gain, fading
`ifdef MIX_CLIP_HOLD_EN
      , output clip_led
`endif
   );
endinterface

// File: rtl/loop_overdub_mixer.sv
// rtl/loop_overdub_mixer.sv - dry + ramped wet mix with saturation, one result per sample_tick
// Define MIX_CLIP_HOLD_EN to add the clip hold counter and clip_led output.
module loop_overdub_mixer #(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 8,
   parameter int STEP   = 16
`ifdef MIX_CLIP_HOLD_EN
   , parameter int CLIP_HOLD = 4800
`endif
) (
   input logic clk,
   input logic reset,
   loop_overdub_mixer_if.slave mix
);
   localparam int GW = GAIN_W + 2;
   localparam int GQ = GAIN_W + 1;
   localparam int PW = DATA_W + GAIN_W + 2;
   localparam int SW = DATA_W + 2;

   localparam logic [GW-1:0] FULL_G = GW'(2 ** GAIN_W);
   localparam logic [GW-1:0] STEP_G = GW'(STEP);
   localparam logic signed [SW-1:0] MAX_S = {3'b000, {(DATA_W-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_S = {3'b111, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {MUTED, FADE_IN, ON, FADE_OUT} mixStateT;

   mixStateT                 stateQ, stateNext;
   logic [GAIN_W:0]          gainQ;
   logic [GW-1:0]            gainExt, gainUp, gainDown, gainNext;
   logic signed [DATA_W-1:0] outQ, outNext;
   logic                     validQ;
   logic signed [PW-1:0]     wetWide, gainWide, product, shifted;
   logic signed [SW-1:0]     sumS, clipped;
   logic                     satHi, satLo;

   // Extra headroom bit so gain+STEP can be compared against FULL without wrapping.
   assign gainExt  = GW'(gainQ);
   assign gainUp   = (gainExt + STEP_G > FULL_G) ? FULL_G : gainExt + STEP_G;
   assign gainDown = (gainExt > STEP_G) ? gainExt - STEP_G : '0;

   always_comb begin
      stateNext = stateQ;
      gainNext  = gainExt;
      case (stateQ)
         MUTED: begin
            if (mix.wet_en) begin
               gainNext  = gainUp;
               stateNext = (gainUp == FULL_G) ? ON : FADE_IN;
            end
         end
         FADE_IN, FADE_OUT: begin
            if (mix.wet_en) begin
               gainNext  = gainUp;
               stateNext = (gainUp == FULL_G) ? ON : FADE_IN;
            end else begin
               gainNext  = gainDown;
               stateNext = (gainDown == '0) ? MUTED : FADE_OUT;
            end
         end
         ON: begin
            if (!mix.wet_en) begin
               gainNext  = gainDown;
               stateNext = (gainDown == '0) ? MUTED : FADE_OUT;
            end
         end
         default: begin
            stateNext = MUTED;
            gainNext  = '0;
         end
      endcase
   end

   // Mix uses the gain in effect before this strobe's update; shift floors toward -inf.
   always_comb begin
      wetWide  = PW'(mix.wet);
      gainWide = PW'(gainQ);
      product  = wetWide * gainWide;
      shifted  = product >>> GAIN_W;
      sumS     = SW'(mix.dry) + SW'(shifted);
      satHi    = sumS > MAX_S;
      satLo    = sumS < MIN_S;
      clipped  = satHi ? MAX_S : (satLo ? MIN_S : sumS);
      outNext  = DATA_W'(clipped);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= MUTED;
         gainQ  <= '0;
         outQ   <= '0;
         validQ <= 1'b0;
      end else if (mix.sample_tick) begin
         stateQ <= stateNext;
         gainQ  <= GQ'(gainNext);
         outQ   <= outNext;
         validQ <= 1'b1;
      end else begin
         validQ <= 1'b0;
      end
   end

   assign mix.out       = outQ;
   assign mix.out_valid = validQ;
   assign mix.gain      = gainQ;
   assign mix.fading    = (stateQ == FADE_IN) || (stateQ == FADE_OUT);

`ifdef MIX_CLIP_HOLD_EN
   localparam int CW = $clog2(CLIP_HOLD + 1);

   logic [CW-1:0] clipCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         clipCnt <= '0;
      end else if (mix.sample_tick) begin
         if (satHi || satLo) begin
            clipCnt <= CW'(CLIP_HOLD);
         end else if (clipCnt != '0) begin
            clipCnt <= clipCnt - CW'(1);
         end
      end
   end

   assign mix.clip_led = (clipCnt != '0);
`endif
endmodule
